// File: rtl/pbvi_pkg.sv
// Shared types and fixed-point constants for the PBVI backup controller.
package pbvi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CMP,
    S_WRITE,
    S_DONE
  } state_t;

  // The dot-product datapath is hard-wired for two hidden states.
  localparam int NUM_S = 2;

  // Belief is Q0.16, gamma is Q8.8; products carry 24 fraction bits,
  // and the result drops back to the gamma format.
  localparam int BEL_FRAC  = 16;
  localparam int GAM_FRAC  = 8;
  localparam int PROD_FRAC = BEL_FRAC + GAM_FRAC;
  localparam int RES_FRAC  = GAM_FRAC;
  localparam int Q_SHIFT   = PROD_FRAC - RES_FRAC;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/pbvi_dot2.sv
// Combinational two-term unsigned x signed multiply-add, scaled back to Q8.8
// with an arithmetic shift and saturated to the signed W-bit range.
module pbvi_dot2
  import pbvi_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] bel_s0,
  input  logic [W-1:0] bel_s1,
  input  logic [W-1:0] gam_s0,
  input  logic [W-1:0] gam_s1,
  output logic [W-1:0] val
);

  localparam int PW = 2 * W + 1;
  localparam int SW = PW + 1;

  localparam logic signed [SW-1:0] HI = SW'(SAT_MAX);
  localparam logic signed [SW-1:0] LO = SW'(SAT_MIN);

  logic signed [PW-1:0] bel0_x, bel1_x, gam0_x, gam1_x;
  logic signed [PW-1:0] prod0, prod1;
  logic signed [SW-1:0] sum, shifted;

  always_comb begin
    // Zero-extend beliefs and sign-extend gammas so the signed multiply is exact.
    bel0_x  = $signed({{(W + 1){1'b0}}, bel_s0});
    bel1_x  = $signed({{(W + 1){1'b0}}, bel_s1});
    gam0_x  = $signed({{(W + 1){gam_s0[W-1]}}, gam_s0});
    gam1_x  = $signed({{(W + 1){gam_s1[W-1]}}, gam_s1});
    prod0   = bel0_x * gam0_x;
    prod1   = bel1_x * gam1_x;
    sum     = $signed({prod0[PW-1], prod0}) + $signed({prod1[PW-1], prod1});
    shifted = sum >>> Q_SHIFT;
    if (shifted > HI) begin
      val = W'(SAT_MAX);
    end else if (shifted < LO) begin
      val = W'(SAT_MIN);
    end else begin
      val = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/pbvi_backup_ctrl.sv
// PBVI backup sequencer: scores every action per belief with one shared
// dot-product unit and writes the best action/value for each belief.
module pbvi_backup_ctrl
  import pbvi_pkg::*;
#(
  parameter int NUM_S = pbvi_pkg::NUM_S,
  parameter int NUM_A = 3,
  parameter int NUM_B = 100,
  parameter int W     = 16,
  parameter int BW    = $clog2(NUM_B),
  parameter int AW    = $clog2(NUM_A)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [BW-1:0] rd_b_idx,
  output logic [AW-1:0] rd_a_idx,
  input  logic [W-1:0]  bel_s0,
  input  logic [W-1:0]  bel_s1,
  input  logic [W-1:0]  gam_s0,
  input  logic [W-1:0]  gam_s1,
  output logic          res_we,
  output logic [BW-1:0] res_b_idx,
  output logic [AW-1:0] res_action,
  output logic [W-1:0]  res_value
);

  if (NUM_S != pbvi_pkg::NUM_S) begin : g_num_s_check
    $error("pbvi_backup_ctrl: datapath supports exactly two hidden states");
  end

  localparam logic [AW-1:0] A_LAST = AW'(NUM_A - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NUM_B - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [AW-1:0] a_q, a_d;
  logic [W-1:0]  best_val_q, best_val_d;
  logic [AW-1:0] best_act_q, best_act_d;
  logic [W-1:0]  val_q, dot_val;
  logic          busy_d, done_d, rd_en_d, res_we_d;

  pbvi_dot2 #(.W(W)) u_dot2 (
    .bel_s0 (bel_s0),
    .bel_s1 (bel_s1),
    .gam_s0 (gam_s0),
    .gam_s1 (gam_s1),
    .val    (dot_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = S_CMP;
      S_CMP:   state_d = (a_q == A_LAST) ? S_WRITE : S_ADDR;
      S_WRITE: state_d = (b_q == B_LAST) ? S_DONE : S_ADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Loop counters and running best; ties keep the lower action index.
  always_comb begin
    b_d        = b_q;
    a_d        = a_q;
    best_val_d = best_val_q;
    best_act_d = best_act_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d        = '0;
          a_d        = '0;
          best_val_d = W'(SAT_MIN);
          best_act_d = '0;
        end
      end
      S_CMP: begin
        if (a_q == '0 || $signed(val_q) > $signed(best_val_q)) begin
          best_val_d = val_q;
          best_act_d = a_q;
        end
        if (a_q != A_LAST) a_d = a_q + 1'b1;
      end
      S_WRITE: begin
        if (b_q != B_LAST) begin
          b_d        = b_q + 1'b1;
          a_d        = '0;
          best_val_d = W'(SAT_MIN);
          best_act_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state and then registered.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    rd_en_d  = (state_d == S_ADDR);
    res_we_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q        <= '0;
      a_q        <= '0;
      best_val_q <= '0;
      best_act_q <= '0;
      val_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      res_we     <= 1'b0;
      rd_b_idx   <= '0;
      rd_a_idx   <= '0;
      res_b_idx  <= '0;
      res_action <= '0;
      res_value  <= '0;
    end else begin
      b_q        <= b_d;
      a_q        <= a_d;
      best_val_q <= best_val_d;
      best_act_q <= best_act_d;
      if (state_q == S_DATA) val_q <= dot_val;
      busy   <= busy_d;
      done   <= done_d;
      rd_en  <= rd_en_d;
      res_we <= res_we_d;
      if (rd_en_d) begin
        rd_b_idx <= b_d;
        rd_a_idx <= a_d;
      end
      if (res_we_d) begin
        res_b_idx  <= b_d;
        res_action <= best_act_d;
        res_value  <= best_val_d;
      end
    end
  end

endmodule

// File: tb/tb_pbvi_backup_ctrl.sv
// Scoreboard bench for pbvi_backup_ctrl: directed belief/gamma tables with
// hand-computed results, sweep latency, ignored start and mid-sweep reset.
module tb_pbvi_backup_ctrl;

  localparam int NUM_A    = 3;
  localparam int NUM_B    = 100;
  localparam int W        = 16;
  localparam int BW       = 7;
  localparam int AW       = 2;
  localparam int DONE_CYC = NUM_B * (3 * NUM_A + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, rd_en, res_we;
  logic [BW-1:0] rd_b_idx, res_b_idx;
  logic [AW-1:0] rd_a_idx, res_action;
  logic [W-1:0]  bel_s0, bel_s1, gam_s0, gam_s1, res_value;

  pbvi_backup_ctrl #(
    .NUM_A (NUM_A),
    .NUM_B (NUM_B),
    .W     (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_b_idx   (rd_b_idx),
    .rd_a_idx   (rd_a_idx),
    .bel_s0     (bel_s0),
    .bel_s1     (bel_s1),
    .gam_s0     (gam_s0),
    .gam_s1     (gam_s1),
    .res_we     (res_we),
    .res_b_idx  (res_b_idx),
    .res_action (res_action),
    .res_value  (res_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] b;
    logic [AW-1:0] act;
    logic [W-1:0]  val;
  } res_t;

  res_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int e0 = 0;
  int res_cnt = 0;
  int done_cnt = 0;
  logic prev_we = 1'b0;

  logic [W-1:0]  bel0_t[NUM_B];
  logic [W-1:0]  bel1_t[NUM_B];
  logic [W-1:0]  g0_t[NUM_B][NUM_A];
  logic [W-1:0]  g1_t[NUM_B][NUM_A];
  logic [AW-1:0] ea_t[NUM_B];
  logic [W-1:0]  ev_t[NUM_B];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt - e0);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Storage with one-cycle read latency.
  always @(negedge clk) begin
    if (rd_en) begin
      bel_s0 = bel0_t[rd_b_idx];
      bel_s1 = bel1_t[rd_b_idx];
      gam_s0 = g0_t[rd_b_idx][rd_a_idx];
      gam_s1 = g1_t[rd_b_idx][rd_a_idx];
    end
  end

  // Monitor: pops an expected result whenever the DUT writes one.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (res_we) begin
        check("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
        res_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: b=%0d action=%0d value=0x%0h", res_b_idx, res_action, res_value);
        end else begin
          e = exp_q.pop_front();
          check("res_b_idx", {25'd0, res_b_idx}, {25'd0, e.b});
          check("res_action", {30'd0, res_action}, {30'd0, e.act});
          check("res_value", {16'd0, res_value}, {16'd0, e.val});
        end
      end
      if (done) begin
        done_cnt++;
        check("done_cycle", edge_cnt - e0, DONE_CYC);
        check("busy_at_done", {31'd0, busy}, 32'd1);
      end
      prev_we = res_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic set_row(input int b, input logic [W-1:0] b0, input logic [W-1:0] b1,
                         input logic [W-1:0] ga0, input logic [W-1:0] gb0,
                         input logic [W-1:0] ga1, input logic [W-1:0] gb1,
                         input logic [W-1:0] ga2, input logic [W-1:0] gb2,
                         input logic [AW-1:0] act, input logic [W-1:0] val);
    bel0_t[b] = b0;  bel1_t[b] = b1;
    g0_t[b][0] = ga0; g1_t[b][0] = gb0;
    g0_t[b][1] = ga1; g1_t[b][1] = gb1;
    g0_t[b][2] = ga2; g1_t[b][2] = gb2;
    ea_t[b] = act;   ev_t[b] = val;
  endtask

  task automatic load_tables();
    for (int b = 0; b < NUM_B; b++) begin
      if (b < 20)      // action 1 clearly best
        set_row(b, 16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0080, 16'h0080, 2'd1, 16'h0200);
      else if (b < 40) // three-way tie
        set_row(b, 16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 2'd0, 16'h0100);
      else if (b < 60) // a2 higher by one LSB
        set_row(b, 16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0101, 16'h0101, 2'd2, 16'h0101);
      else if (b < 70) // positive saturation, a1/a2 tie at the ceiling
        set_row(b, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2'd1, 16'h7FFF);
      else if (b < 80) // negative saturation for every action
        set_row(b, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'd0, 16'h8000);
      else             // mixed signs: -1.0, +0.25, -0.5
        set_row(b, 16'h4000, 16'hC000, 16'hFF00, 16'hFF00, 16'h0400, 16'hFF00, 16'hFE00, 16'h0000, 2'd1, 16'h0040);
    end
  endtask

  task automatic push_expected(input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({BW'(b), ea_t[b], ev_t[b]});
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    e0 = edge_cnt;
    @(negedge clk);
    start = 1'b0;
    check("rd_en_cycle1", {31'd0, rd_en}, 32'd1);
    check("busy_cycle1", {31'd0, busy}, 32'd1);
    check("rd_idx_cycle1", {23'd0, rd_b_idx, rd_a_idx}, 32'd0);
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while ((edge_cnt - e0) != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_cycle", edge_cnt - e0, target);
  endtask

  task automatic finish_sweep();
    int n = 0;
    while (!done && n < DONE_CYC + 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("res_count", res_cnt, NUM_B);
    check("done_count", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bel_s0 = '0; bel_s1 = '0; gam_s0 = '0; gam_s1 = '0;
    load_tables();
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, rd_en, res_we, rd_b_idx, rd_a_idx, res_b_idx, res_action}, 32'd0);
    check("reset_value", {16'd0, res_value}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep with a start pulse mid-run that must be ignored.
    push_expected(NUM_B);
    kick();
    wait_cycle(500);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_sweep();

    // Reset while belief 50 is being scored.
    res_cnt = 0;
    done_cnt = 0;
    push_expected(50);
    kick();
    wait_cycle(505);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {busy, done, rd_en, res_we}, 4'd0);
    check("midreset_rd_idx", {23'd0, rd_b_idx, rd_a_idx}, 32'd0);
    check("midreset_res_idx", {23'd0, res_b_idx, res_action}, 32'd0);
    check("midreset_value", {16'd0, res_value}, 32'd0);
    check("midreset_res_count", res_cnt, 50);
    check("midreset_queue", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    res_cnt = 0;
    done_cnt = 0;

    // Restart must begin again at belief 0 and complete a full sweep.
    push_expected(NUM_B);
    kick();
    finish_sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pbvi_backup_ctrl.md
# pbvi_backup_ctrl

Sequencer for the PBVI backup step. For each stored belief point it scores every action's gamma vector against that belief with a dot product over the two hidden states. It then selects the maximizing action and writes the action index and value to the policy result port. It sits between the belief/gamma storage and the policy output, reusing one dot-product unit for all (belief, action) pairs.

## Interface
- `NUM_S`, default 2: hidden states; the datapath is fixed for 2 states.
- `NUM_A`, default 3: actions scored per belief.
- `NUM_B`, default 100: belief points.
- `W`, default 16: data width.
- `BW`, default `$clog2(NUM_B)`: belief index width.
- `AW`, default `$clog2(NUM_A)`: action index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a full sweep; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the sweep completes.
- `rd_en` out 1: storage read strobe.
- `rd_b_idx` out BW: belief index to read.
- `rd_a_idx` out AW: action index to read.
- `bel_s0`, `bel_s1` in W: belief probabilities, unsigned Q0.16, valid the cycle after `rd_en`.
- `gam_s0`, `gam_s1` in W: gamma entries, signed Q8.8, valid the cycle after `rd_en`.
- `res_we` out 1: result write strobe.
- `res_b_idx` out BW: belief index of the result.
- `res_action` out AW: best action.
- `res_value` out W: best value, signed Q8.8.

## Operation
- States: IDLE, ADDR, DATA, CMP, WRITE, DONE.
- IDLE
  - `start`=1 → ADDR; clear b=0, a=0, best_val=most-negative (0x8000), best_act=0.
- ADDR
  - Drive `rd_en`=1 with `rd_b_idx`=b and `rd_a_idx`=a.
  - Go to DATA.
- DATA
  - Compute sum = `bel_s0`·`gam_s0` + `bel_s1`·`gam_s1`: unsigned×signed products are 33-bit signed, the sum is 34-bit.
  - Register val = sum >>> 16 (arithmetic shift), saturated to the signed 16-bit range [0x8000, 0x7FFF].
  - Go to CMP.
- CMP
  - If a==0 or val > best_val (strict), load best_val=val and best_act=a.
  - Ties keep the lower action index.
  - If a<NUM_A-1: a++ and go to ADDR. Otherwise go to WRITE.
- WRITE
  - `res_we`=1 with `res_b_idx`=b, `res_action`=best_act, `res_value`=best_val.
  - If b<NUM_B-1: b++, a=0, reset best, go to ADDR. Otherwise go to DONE.
- DONE
  - `done`=1, then go to IDLE.
- `start` in any non-IDLE state is ignored; there is no queuing.
- Reset, including mid-sweep: state goes to IDLE, b and a go to 0, and every output goes to 0 (`busy`, `done`, `rd_en`, `res_we`, all indices, `res_action`, `res_value`). A later `start` restarts at b=0.

## Timing
- Storage read latency is fixed at 1 cycle, with no backpressure.
- Each action takes 3 cycles (ADDR, DATA, CMP); each belief takes 3·NUM_A+1 cycles.
- `start` sampled at edge 0 gives `rd_en` high in cycle 1. `done` is high in the cycle after edge NUM_B·(3·NUM_A+1)+1, which is cycle 1001 for the defaults.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and is low the next cycle.
- `res_we` pulses exactly NUM_B times per sweep, never back-to-back, with `res_b_idx` ascending 0..NUM_B-1.
- `rd_en`, `res_we` and `done` are registered single-cycle pulses.

## Structure
- Package `pbvi_pkg` holds:
  - the state enum;
  - the Q-format constants: belief frac=16, gamma frac=8, shift=16;
  - the saturation bounds 0x7FFF/0x8000;
  - the NUM_S=2 constant.
- Sub-module `pbvi_dot2` is a combinational two-term unsigned×signed multiply-add with shift and saturation. The controller registers its output in DATA.

## Test plan
- Action 1 best: all beliefs (0x8000,0x8000); gammas a0=(0x0100,0x0100), a1=(0x0200,0x0200), a2=(0x0080,0x0080) → every result has action=1, value=0x0200.
- Tie: all gammas (0x0100,0x0100) → action=0 for every b; a mix with a2 strictly higher by 1 LSB → action=2.
- Saturation:
  - belief (0xFFFF,0xFFFF) with gamma (0x7FFF,0x7FFF) → value=0x7FFF;
  - same belief with gamma (0x8000,0x8000) for all actions → value=0x8000, action=0.
- Latency: `start` at cycle 0 → exactly 100 `res_we` pulses, `done` a single pulse in cycle 1001, `busy` low in cycle 1002; `start` pulsed at cycle 500 has no effect.
- Reset mid-sweep: `rst_n` low while b=50 → all outputs 0 immediately. A new `start` → first `res_we` has `res_b_idx`=0, and a full 100-result sweep completes.
